hpdmc_iddr_rdcap: RTL and testbench

DDR SDRAM read-capture datapath for the HPDMC controller. It takes the per-bit rising/falling-edge samples from the IDDR2 input primitives on the DQ pads and, after a programmable read latency from the read command, packs one 4-beat burst into a single wide word. It outputs that word with a one-cycle valid strobe. It sits between the pad-level IDDR2 instances and the controller's read data bus, and is the input counterpart of the DDR output register pairs that drive DQ/DQS.

---
 rtl/hpdmc_iddr_rdcap.sv | 92 +++++++++
 tb/tb_hpdmc_iddr_rdcap.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_iddr_rdcap.sv
// Read-capture datapath: packs two IDDR2 beat pairs into one 4-beat burst word
// a programmable number of cycles after the read command.
module hpdmc_iddr_rdcap #(
  parameter int DQ_WIDTH = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    rd_issue,
  input  logic [2:0]              rd_latency,
  input  logic                    swap,
  input  logic [DQ_WIDTH-1:0]     dq_q0,
  input  logic [DQ_WIDTH-1:0]     dq_q1,
  input  logic                    err_clr,
  output logic [4*DQ_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_busy,
  output logic                    rd_err
);

  typedef enum logic {S_IDLE, S_PAIR1} state_t;

  state_t                  state_q;
  logic [7:0]              sr_q, sr_d;
  logic [7:0]              lat_mask;
  logic [2:0]              lat_q, lat_d;
  logic                    acc_prev_q;
  logic                    rd_err_q, rd_err_d;
  logic                    rd_valid_q;
  logic [2*DQ_WIDTH-1:0]   beat01_q;
  logic [4*DQ_WIDTH-1:0]   rd_data_q;
  logic                    accept, reject, tap, busy;
  logic [2*DQ_WIDTH-1:0]   pair_now;

  always_comb begin
    accept   = rd_issue && !acc_prev_q;
    reject   = rd_issue && acc_prev_q;
    tap      = sr_q[lat_q - 3'd1];
    // Bits at or past the tap have already been consumed; dropping them keeps
    // stale marks from re-firing after lat_q grows.
    lat_mask = ~(8'hFF << lat_q);
    sr_d     = {sr_q[6:0], accept} & lat_mask;
    busy     = (|sr_q) || (state_q == S_PAIR1) || rd_valid_q;
    lat_d    = lat_q;
    if (!busy && !rd_issue) begin
      lat_d = (rd_latency == 3'd0) ? 3'd1 : rd_latency;
    end
    rd_err_d = rd_err_q;
    if (err_clr) rd_err_d = 1'b0;
    if (reject)  rd_err_d = 1'b1;
    // Upper half holds the later beat of the pair.
    pair_now = swap ? {dq_q0, dq_q1} : {dq_q1, dq_q0};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      lat_q      <= 3'd1;
      acc_prev_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      beat01_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      sr_q       <= sr_d;
      lat_q      <= lat_d;
      acc_prev_q <= accept;
      rd_err_q   <= rd_err_d;
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tap) begin
            beat01_q <= pair_now;
            state_q  <= S_PAIR1;
          end
        end
        S_PAIR1: begin
          rd_data_q  <= {pair_now, beat01_q};
          rd_valid_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_busy  = busy;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_hpdmc_iddr_rdcap.sv
// Directed bench for hpdmc_iddr_rdcap: per-cycle stimulus tables with
// hand-computed expected valid/busy/err/data, checked by immediate assertions.
module tb_hpdmc_iddr_rdcap;

  localparam int DQ = 16;
  localparam int N  = 32;

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic            rd_issue;
  logic [2:0]      rd_latency;
  logic            swap;
  logic [DQ-1:0]   dq_q0, dq_q1;
  logic            err_clr;
  logic [4*DQ-1:0] rd_data;
  logic            rd_valid, rd_busy, rd_err;

  int checks = 0;
  int errors = 0;

  logic            iss [N];
  logic            clr [N];
  logic            rst [N];
  logic [2:0]      lat_at [N];
  logic [DQ-1:0]   q0 [N];
  logic [DQ-1:0]   q1 [N];
  logic            ev [N];
  logic            eb [N];
  logic            ee [N];
  logic [4*DQ-1:0] ed [N];
  logic [4*DQ-1:0] exp_word;

  hpdmc_iddr_rdcap #(.DQ_WIDTH(DQ)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rd_issue   (rd_issue),
    .rd_latency (rd_latency),
    .swap       (swap),
    .dq_q0      (dq_q0),
    .dq_q1      (dq_q1),
    .err_clr    (err_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_busy    (rd_busy),
    .rd_err     (rd_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n, input logic [2:0] lat);
    rd_issue = 1'b0;
    err_clr = 1'b0;
    rd_latency = lat;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_tables(input logic [2:0] lat);
    for (int c = 0; c < N; c++) begin
      iss[c] = 1'b0; clr[c] = 1'b0; rst[c] = 1'b0; lat_at[c] = lat;
      q0[c] = DQ'($urandom_range(0, 65535));
      q1[c] = DQ'($urandom_range(0, 65535));
      ev[c] = 1'b0; eb[c] = 1'b0; ee[c] = 1'b0; ed[c] = '0;
    end
  endtask

  task automatic set_busy(input int from, input int to);
    for (int c = from; c <= to; c++) eb[c] = 1'b1;
  endtask

  task automatic run(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      rd_issue = iss[c]; err_clr = clr[c]; sys_rst = rst[c];
      rd_latency = lat_at[c]; dq_q0 = q0[c]; dq_q1 = q1[c];
      if (ev[c]) exp_word = ed[c];
      chk($sformatf("%s c%0d valid", name, c), 64'(rd_valid), 64'(ev[c]));
      chk($sformatf("%s c%0d busy", name, c), 64'(rd_busy), 64'(eb[c]));
      chk($sformatf("%s c%0d err", name, c), 64'(rd_err), 64'(ee[c]));
      chk($sformatf("%s c%0d data", name, c), rd_data, exp_word);
      step();
      if (rst[c]) exp_word = '0;
    end
    rd_issue = 1'b0; err_clr = 1'b0; sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; rd_issue = 1'b0; rd_latency = 3'd3; swap = 1'b0;
    dq_q0 = '0; dq_q1 = '0; err_clr = 1'b0; exp_word = '0;
    step(); step();
    sys_rst = 1'b0;
    chk("reset valid", 64'(rd_valid), 64'd0);
    chk("reset busy", 64'(rd_busy), 64'd0);
    chk("reset err", 64'(rd_err), 64'd0);
    chk("reset data", rd_data, 64'd0);

    // L=3, swap=0, single burst
    idle(2, 3'd3);
    clear_tables(3'd3);
    iss[0] = 1'b1;
    q0[3] = 16'h1111; q1[3] = 16'h2222; q0[4] = 16'h3333; q1[4] = 16'h4444;
    ev[5] = 1'b1; ed[5] = 64'h4444_3333_2222_1111;
    set_busy(1, 5);
    run("l3", 9);

    // Same stimulus, swap=1
    swap = 1'b1;
    idle(2, 3'd3);
    clear_tables(3'd3);
    iss[0] = 1'b1;
    q0[3] = 16'h1111; q1[3] = 16'h2222; q0[4] = 16'h3333; q1[4] = 16'h4444;
    ev[5] = 1'b1; ed[5] = 64'h3333_4444_1111_2222;
    set_busy(1, 5);
    run("swap", 9);
    swap = 1'b0;

    // L=1, issues at 0/2/4: full throughput
    idle(2, 3'd1);
    clear_tables(3'd1);
    iss[0] = 1'b1; iss[2] = 1'b1; iss[4] = 1'b1;
    q0[1] = 16'h0101; q1[1] = 16'h0202; q0[2] = 16'h0303; q1[2] = 16'h0404;
    q0[3] = 16'h1111; q1[3] = 16'h1212; q0[4] = 16'h1313; q1[4] = 16'h1414;
    q0[5] = 16'h2121; q1[5] = 16'h2222; q0[6] = 16'h2323; q1[6] = 16'h2424;
    ev[3] = 1'b1; ed[3] = 64'h0404_0303_0202_0101;
    ev[5] = 1'b1; ed[5] = 64'h1414_1313_1212_1111;
    ev[7] = 1'b1; ed[7] = 64'h2424_2323_2222_2121;
    set_busy(1, 7);
    run("thru", 10);

    // L=2, issues at 0/1: second rejected, sticky error, cleared at 10
    idle(2, 3'd2);
    clear_tables(3'd2);
    iss[0] = 1'b1; iss[1] = 1'b1;
    q0[2] = 16'haaaa; q1[2] = 16'hbbbb; q0[3] = 16'hcccc; q1[3] = 16'hdddd;
    ev[4] = 1'b1; ed[4] = 64'hdddd_cccc_bbbb_aaaa;
    set_busy(1, 4);
    for (int c = 2; c <= 10; c++) ee[c] = 1'b1;
    clr[10] = 1'b1;
    run("coll", 13);

    // rd_latency=0 behaves as L=1
    idle(2, 3'd0);
    clear_tables(3'd0);
    iss[0] = 1'b1;
    q0[1] = 16'hf00d; q1[1] = 16'hbeef; q0[2] = 16'hcafe; q1[2] = 16'h1357;
    ev[3] = 1'b1; ed[3] = 64'h1357_cafe_beef_f00d;
    set_busy(1, 3);
    run("lat0", 6);

    // Latency 5 -> 2 mid-read; new latency applies only after draining
    idle(2, 3'd5);
    clear_tables(3'd2);
    lat_at[0] = 3'd5;
    iss[0] = 1'b1; iss[10] = 1'b1;
    q0[5] = 16'h5a5a; q1[5] = 16'h6b6b; q0[6] = 16'h7c7c; q1[6] = 16'h8d8d;
    q0[12] = 16'h1234; q1[12] = 16'h5678; q0[13] = 16'h9abc; q1[13] = 16'hdef0;
    ev[7] = 1'b1; ed[7] = 64'h8d8d_7c7c_6b6b_5a5a;
    ev[14] = 1'b1; ed[14] = 64'hdef0_9abc_5678_1234;
    set_busy(1, 7); set_busy(11, 14);
    run("latchg", 17);

    // Reset at cycle 3 of an L=5 read drops it
    idle(2, 3'd5);
    clear_tables(3'd5);
    iss[0] = 1'b1; rst[3] = 1'b1;
    q0[5] = 16'hdead; q1[5] = 16'hbeef; q0[6] = 16'h0bad; q1[6] = 16'hf00d;
    set_busy(1, 3);
    run("rst", 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
